// File: rtl/bra_rs.sv
// Branch reservation station: age-ordered collapsing queue that wakes
// operands from the CDB and issues the oldest ready branch each cycle.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush         squash all slots and any pending issue
//   disp_*        dispatch request (valid/ready, opcode, operands, tags)
//   cdb_*         common-data-bus broadcast (valid, tag, value)
//   iss_*         registered issue bundle to the BRA unit (op 0 = none)
//   occupancy     number of valid slots
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module bra_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = `ROB_ENTRY_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [3:0]                     disp_op,
    input  logic                           disp_qj_busy,
    input  logic                           disp_qk_busy,
    input  logic [TAG_W-1:0]               disp_qj,
    input  logic [TAG_W-1:0]               disp_qk,
    input  logic [31:0]                    disp_vj,
    input  logic [31:0]                    disp_vk,
    input  logic [31:0]                    disp_pc,
    input  logic [31:0]                    disp_offset,
    input  logic [TAG_W-1:0]               disp_dest,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [31:0]                    cdb_val,
    output logic [3:0]                     iss_op,
    output logic [31:0]                    iss_srca,
    output logic [31:0]                    iss_srcb,
    output logic [31:0]                    iss_pc,
    output logic [31:0]                    iss_offset,
    output logic [TAG_W-1:0]               iss_dest,
    output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

    localparam int OW = $clog2(ENTRIES + 1);

    typedef struct packed {
        logic             vld;
        logic [3:0]       op;
        logic             qjb;
        logic             qkb;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      pc;
        logic [31:0]      off;
        logic [TAG_W-1:0] dest;
    } slot_t;

    slot_t            slot_q [ENTRIES];
    slot_t            slot_d [ENTRIES];
    slot_t            upd    [ENTRIES];
    slot_t            new_e;
    slot_t            iss_sel;
    logic [OW-1:0]    occ_q, occ_d, wr_idx;
    logic [3:0]       iss_op_q, iss_op_d;
    logic [31:0]      iss_srca_q, iss_srca_d;
    logic [31:0]      iss_srcb_q, iss_srcb_d;
    logic [31:0]      iss_pc_q, iss_pc_d;
    logic [31:0]      iss_off_q, iss_off_d;
    logic [TAG_W-1:0] iss_dest_q, iss_dest_d;
    logic [ENTRIES-1:0] rdy;
    logic             iss_hit;
    logic             disp_acc;
    int               iss_idx;

    assign disp_ready = (occ_q < OW'(ENTRIES));
    assign occupancy  = occ_q;
    assign iss_op     = iss_op_q;
    assign iss_srca   = iss_srca_q;
    assign iss_srcb   = iss_srcb_q;
    assign iss_pc     = iss_pc_q;
    assign iss_offset = iss_off_q;
    assign iss_dest   = iss_dest_q;

    always_comb begin
        // Incoming entry, forwarding a same-cycle broadcast.
        new_e      = '0;
        new_e.vld  = 1'b1;
        new_e.op   = disp_op;
        new_e.qjb  = disp_qj_busy;
        new_e.qkb  = disp_qk_busy;
        new_e.qj   = disp_qj;
        new_e.qk   = disp_qk;
        new_e.vj   = disp_vj;
        new_e.vk   = disp_vk;
        new_e.pc   = disp_pc;
        new_e.off  = disp_offset;
        new_e.dest = disp_dest;
        if (cdb_valid && disp_qj_busy && disp_qj == cdb_tag) begin
            new_e.qjb = 1'b0;
            new_e.vj  = cdb_val;
        end
        if (cdb_valid && disp_qk_busy && disp_qk == cdb_tag) begin
            new_e.qkb = 1'b0;
            new_e.vk  = cdb_val;
        end

        // Readiness from registered state; wakeups apply to the next state.
        for (int i = 0; i < ENTRIES; i++) begin
            rdy[i] = slot_q[i].vld & ~slot_q[i].qjb & ~slot_q[i].qkb;
            upd[i] = slot_q[i];
            if (cdb_valid && slot_q[i].vld) begin
                if (slot_q[i].qjb && slot_q[i].qj == cdb_tag) begin
                    upd[i].qjb = 1'b0;
                    upd[i].vj  = cdb_val;
                end
                if (slot_q[i].qkb && slot_q[i].qk == cdb_tag) begin
                    upd[i].qkb = 1'b0;
                    upd[i].vk  = cdb_val;
                end
            end
        end

        // Lowest index wins: scan downward so the last hit is the oldest.
        iss_hit = 1'b0;
        iss_idx = 0;
        iss_sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                iss_hit = 1'b1;
                iss_idx = i;
                iss_sel = slot_q[i];
            end
        end

        // Collapse entries above the issued slot.
        for (int i = 0; i < ENTRIES; i++) begin
            slot_d[i] = upd[i];
            if (iss_hit && i >= iss_idx) slot_d[i] = '0;
        end
        for (int i = 0; i < ENTRIES - 1; i++) begin
            if (iss_hit && i >= iss_idx) slot_d[i] = upd[i+1];
        end

        disp_acc = disp_valid && disp_ready && (disp_op != 4'd0);
        wr_idx   = occ_q - OW'(iss_hit);
        for (int i = 0; i < ENTRIES; i++) begin
            if (disp_acc && wr_idx == OW'(i)) slot_d[i] = new_e;
        end
        occ_d = occ_q + OW'(disp_acc) - OW'(iss_hit);

        iss_op_d   = iss_hit ? iss_sel.op   : '0;
        iss_srca_d = iss_hit ? iss_sel.vj   : '0;
        iss_srcb_d = iss_hit ? iss_sel.vk   : '0;
        iss_pc_d   = iss_hit ? iss_sel.pc   : '0;
        iss_off_d  = iss_hit ? iss_sel.off  : '0;
        iss_dest_d = iss_hit ? iss_sel.dest : '0;

        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) slot_d[i] = '0;
            occ_d      = '0;
            iss_op_d   = '0;
            iss_srca_d = '0;
            iss_srcb_d = '0;
            iss_pc_d   = '0;
            iss_off_d  = '0;
            iss_dest_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= '0;
            occ_q      <= '0;
            iss_op_q   <= '0;
            iss_srca_q <= '0;
            iss_srcb_q <= '0;
            iss_pc_q   <= '0;
            iss_off_q  <= '0;
            iss_dest_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) slot_q[i] <= slot_d[i];
            occ_q      <= occ_d;
            iss_op_q   <= iss_op_d;
            iss_srca_q <= iss_srca_d;
            iss_srcb_q <= iss_srcb_d;
            iss_pc_q   <= iss_pc_d;
            iss_off_q  <= iss_off_d;
            iss_dest_q <= iss_dest_d;
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// Testbench for bra_rs: table of per-cycle vectors plus hand-built
// sequences for full/drop, collapse, flush and asynchronous reset.
module tb_bra_rs;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] off;
        logic [3:0]  dest;
        logic [2:0]  occ;
        logic        rdy;
    } out_t;

    typedef struct packed {
        logic        dv;
        logic [3:0]  op;
        logic        qjb;
        logic [3:0]  qj;
        logic        qkb;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] pc;
        logic [31:0] off;
        logic [3:0]  dest;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        fl;
        out_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_op = '0;
    logic        disp_qj_busy = 1'b0;
    logic        disp_qk_busy = 1'b0;
    logic [3:0]  disp_qj = '0;
    logic [3:0]  disp_qk = '0;
    logic [31:0] disp_vj = '0;
    logic [31:0] disp_vk = '0;
    logic [31:0] disp_pc = '0;
    logic [31:0] disp_offset = '0;
    logic [3:0]  disp_dest = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_val = '0;
    logic [3:0]  iss_op;
    logic [31:0] iss_srca, iss_srcb, iss_pc, iss_offset;
    logic [3:0]  iss_dest;
    logic [2:0]  occupancy;

    int n_total = 0;
    int n_pass  = 0;
    vec_t tbl[$];
    logic [3:0] tg [4] = '{4'd8, 4'd8, 4'd10, 4'd11};

    always #5 clk = ~clk;

    bra_rs #(.ENTRIES(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_pc(disp_pc), .disp_offset(disp_offset),
        .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .iss_op(iss_op), .iss_srca(iss_srca), .iss_srcb(iss_srcb),
        .iss_pc(iss_pc), .iss_offset(iss_offset), .iss_dest(iss_dest),
        .occupancy(occupancy)
    );

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t dsp(input logic [3:0] op,
                                 input logic qjb, input logic [3:0] qj,
                                 input logic qkb, input logic [3:0] qk,
                                 input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [31:0] pc, input logic [31:0] off,
                                 input logic [3:0] dest);
        vec_t v;
        v = '0;
        v.dv = 1'b1; v.op = op;
        v.qjb = qjb; v.qj = qj; v.qkb = qkb; v.qk = qk;
        v.vj = vj; v.vk = vk; v.pc = pc; v.off = off; v.dest = dest;
        return v;
    endfunction

    function automatic vec_t cdb(input vec_t v, input logic [3:0] t,
                                 input logic [31:0] val);
        vec_t r;
        r = v;
        r.cv = 1'b1; r.ct = t; r.cval = val;
        return r;
    endfunction

    function automatic out_t ex(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] pc,
                                input logic [31:0] off, input logic [3:0] d,
                                input logic [2:0] occ, input logic rdy);
        out_t o;
        o.op = op; o.a = a; o.b = b; o.pc = pc; o.off = off;
        o.dest = d; o.occ = occ; o.rdy = rdy;
        return o;
    endfunction

    function automatic out_t z(input logic [2:0] occ, input logic rdy);
        return ex(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, occ, rdy);
    endfunction

    function automatic vec_t w(input vec_t v, input out_t e);
        vec_t r;
        r = v;
        r.e = e;
        return r;
    endfunction

    function automatic out_t cur();
        return ex(iss_op, iss_srca, iss_srcb, iss_pc, iss_offset,
                  iss_dest, occupancy, disp_ready);
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp_o);
        n_total++;
        if (act !== exp_o)
            $display("FAIL %s: got %h expected %h", nm, act, exp_o);
        else
            n_pass++;
    endtask

    task automatic run(input vec_t v, input string nm);
        disp_valid   = v.dv;
        disp_op      = v.op;
        disp_qj_busy = v.qjb;
        disp_qj      = v.qj;
        disp_qk_busy = v.qkb;
        disp_qk      = v.qk;
        disp_vj      = v.vj;
        disp_vk      = v.vk;
        disp_pc      = v.pc;
        disp_offset  = v.off;
        disp_dest    = v.dest;
        cdb_valid    = v.cv;
        cdb_tag      = v.ct;
        cdb_val      = v.cval;
        flush        = v.fl;
        @(posedge clk);
        #1;
        check(nm, cur(), v.e);
    endtask

    initial begin
        vec_t fv;

        // Basic issue, CDB wakeup, same-cycle forward, op 0 drop,
        // dispatch+issue in one cycle, oldest-first among two ready.
        tbl.push_back(w(idle(), z(0, 1)));
        tbl.push_back(w(dsp(1, 0, 0, 0, 0, 5, 5, 'h100, 'h20, 3), z(1, 1)));
        tbl.push_back(w(idle(), ex(1, 5, 5, 'h100, 'h20, 3, 0, 1)));
        tbl.push_back(w(idle(), z(0, 1)));
        tbl.push_back(w(dsp(2, 1, 2, 0, 0, 0, 'hA, 'h200, 8, 4), z(1, 1)));
        tbl.push_back(w(idle(), z(1, 1)));
        tbl.push_back(w(cdb(idle(), 2, 7), z(1, 1)));
        tbl.push_back(w(idle(), ex(2, 7, 'hA, 'h200, 8, 4, 0, 1)));
        tbl.push_back(w(idle(), z(0, 1)));
        tbl.push_back(w(cdb(dsp(1, 0, 0, 1, 5, 'h11, 0, 'h300, 4, 6), 5, 'h99),
                        z(1, 1)));
        tbl.push_back(w(idle(), ex(1, 'h11, 'h99, 'h300, 4, 6, 0, 1)));
        tbl.push_back(w(dsp(0, 0, 0, 0, 0, 1, 1, 'h900, 0, 9), z(0, 1)));
        tbl.push_back(w(dsp(3, 0, 0, 0, 0, 1, 2, 'h400, 0, 1), z(1, 1)));
        tbl.push_back(w(dsp(4, 0, 0, 0, 0, 3, 4, 'h404, 0, 2),
                        ex(3, 1, 2, 'h400, 0, 1, 1, 1)));
        tbl.push_back(w(idle(), ex(4, 3, 4, 'h404, 0, 2, 0, 1)));
        tbl.push_back(w(idle(), z(0, 1)));
        tbl.push_back(w(dsp(5, 1, 12, 0, 0, 0, 1, 'h600, 0, 5), z(1, 1)));
        tbl.push_back(w(dsp(6, 1, 12, 0, 0, 0, 2, 'h604, 0, 6), z(2, 1)));
        tbl.push_back(w(cdb(idle(), 3, 'hEE), z(2, 1)));
        tbl.push_back(w(cdb(idle(), 12, 'hCC), z(2, 1)));
        tbl.push_back(w(idle(), ex(5, 'hCC, 1, 'h600, 0, 5, 1, 1)));
        tbl.push_back(w(idle(), ex(6, 'hCC, 2, 'h604, 0, 6, 0, 1)));

        #12;
        check("reset_state", cur(), z(0, 1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], $sformatf("tbl[%0d]", i));

        // Fill with blocked slots, drop when full, wake slot 2 and
        // carry a wakeup through the collapse.
        for (int i = 0; i < 4; i++)
            run(w(dsp(4'(i + 1), 1, tg[i], 0, 0, 0, 32'((i + 1) * 16),
                      32'('h500 + 4 * i), 0, 4'(i + 1)),
                  z(3'(i + 1), i < 3)), $sformatf("fill%0d", i));
        run(w(dsp(7, 0, 0, 0, 0, 'hDD, 'hDD, 'hF00, 0, 'hF), z(4, 0)),
            "full_drop");
        run(w(cdb(idle(), 10, 'h77), z(4, 0)), "wake_s2");
        run(w(cdb(idle(), 11, 'h55), ex(3, 'h77, 'h30, 'h508, 0, 3, 3, 1)),
            "iss_s2");
        run(w(idle(), ex(4, 'h55, 'h40, 'h50C, 0, 4, 2, 1)), "iss_shifted");
        run(w(cdb(idle(), 8, 'h88), z(2, 1)), "wake_two");
        fv = dsp(7, 0, 0, 0, 0, 1, 1, 'hA00, 0, 7);
        fv.fl = 1'b1;
        run(w(fv, z(0, 1)), "flush");
        run(w(idle(), z(0, 1)), "post_flush");

        // Asynchronous reset between edges with three slots valid.
        for (int i = 0; i < 3; i++)
            run(w(dsp(4'(i + 1), 1, 13, 0, 0, 0, 32'('hB1 + i),
                      32'('h800 + 4 * i), 0, 4'(i + 1)),
                  z(3'(i + 1), 1)), $sformatf("pre%0d", i));
        run(w(cdb(idle(), 13, 'hAB), z(3, 1)), "wake3");
        run(w(dsp(4, 1, 14, 0, 0, 0, 'hB4, 'h80C, 0, 4),
              ex(1, 'hAB, 'hB1, 'h800, 0, 1, 3, 1)), "iss_before_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", cur(), z(0, 1));
        @(negedge clk);
        rst_n = 1'b1;
        run(w(dsp(7, 0, 0, 0, 0, 'h21, 'h22, 'h700, 'h10, 7), z(1, 1)),
            "post_disp");
        run(w(cdb(idle(), 13, 'h1), ex(7, 'h21, 'h22, 'h700, 'h10, 7, 0, 1)),
            "post_iss");
        run(w(idle(), z(0, 1)), "post_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
